// File: rtl/synq_pkg.sv
// Shared types for the SyNCiN op dispatcher:
// sequencer states, op codes and datapath widths.
package synq_pkg;

    localparam int LANE_W = 16;
    localparam int XLEN   = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RES,
        S_RESP,
        S_ERR_RESP
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_2   = 3'd1;
    localparam logic [2:0] OP_3   = 3'd2;
    localparam logic [2:0] OP_4   = 3'd3;
    localparam logic [2:0] OP_5   = 3'd4;

endpackage

// File: rtl/synq_op_timer.sv
// Saturating watchdog counter for the op dispatcher.
// expired is high once the count reaches LIMIT-1.
module synq_op_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != W'(LIMIT)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = cnt >= W'(LIMIT - 1);

endmodule

// File: rtl/synq_op_dispatcher.sv
// Sequencer between the PCPI front-end and the half-precision
// op units: issue lanes, collect one result, respond or abort.
module synq_op_dispatcher
    import synq_pkg::*;
#(
    parameter int NUM_OPS        = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [XLEN-1:0]          cmd_rs1,
    input  logic [XLEN-1:0]          cmd_rs2,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [XLEN-1:0]          rsp_data,
    output logic                     rsp_err,
    output logic [LANE_W-1:0]        op_a,
    output logic [LANE_W-1:0]        op_b,
    output logic [LANE_W-1:0]        op_c,
    output logic [LANE_W-1:0]        op_d,
    output logic [NUM_OPS-1:0]       op_stb,
    input  logic [NUM_OPS-1:0]       op_busy,
    input  logic [NUM_OPS*LANE_W-1:0] res_data,
    input  logic [NUM_OPS-1:0]       res_stb,
    output logic [NUM_OPS-1:0]       res_ack
);

    state_t              state;
    logic [NUM_OPS-1:0]  sel;
    logic [NUM_OPS-1:0]  oh;
    logic [LANE_W-1:0]   res_mux;
    logic                illegal;
    logic                wide;
    logic                take;
    logic                issue_hs;
    logic                res_hit;
    logic                tmo;
    logic                tmr_clr;
    logic                tmr_en;

    assign illegal  = int'(cmd_op) >= NUM_OPS;
    assign oh       = NUM_OPS'(1) << cmd_op;
    assign wide     = (cmd_op == OP_ADD) || (cmd_op == OP_2);
    assign take     = (state == S_IDLE) && cmd_ready && cmd_valid;
    assign issue_hs = |(op_stb & op_busy);
    assign res_hit  = |(res_stb & sel & ~res_ack);

    // Clearing throughout IDLE makes ISSUE start at zero.
    assign tmr_clr = (state == S_IDLE)
                  || (state == S_ISSUE && issue_hs);
    assign tmr_en  = (state == S_ISSUE)
                  || (state == S_WAIT_RES);

    always_comb begin
        res_mux = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (sel[k]) begin
                res_mux = res_mux | res_data[k*LANE_W +: LANE_W];
            end
        end
    end

    synq_op_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(tmo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_c      <= '0;
            op_d      <= '0;
            op_stb    <= '0;
            res_ack   <= '0;
            sel       <= '0;
        end else begin
            res_ack <= '0;
            unique case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (take) begin
                        cmd_ready <= 1'b0;
                        if (illegal) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            state     <= S_ERR_RESP;
                        end else begin
                            sel    <= oh;
                            op_stb <= oh;
                            op_a   <= wide ? cmd_rs1[31:16]
                                           : cmd_rs2[31:16];
                            op_b   <= cmd_rs1[15:0];
                            op_c   <= cmd_rs2[31:16];
                            op_d   <= cmd_rs2[15:0];
                            state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue_hs) begin
                        op_stb <= '0;
                        state  <= S_WAIT_RES;
                    end else if (tmo) begin
                        op_stb    <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        state     <= S_ERR_RESP;
                    end
                end
                S_WAIT_RES: begin
                    if (res_hit) begin
                        res_ack   <= sel;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= {{(XLEN-LANE_W){1'b0}}, res_mux};
                        state     <= S_RESP;
                    end else if (tmo) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        state     <= S_ERR_RESP;
                    end
                end
                S_RESP, S_ERR_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_synq_op_dispatcher.sv
// Directed and randomized bench for synq_op_dispatcher
// with a small behavioural model of the op units.
module tb_synq_op_dispatcher;

    localparam int N     = 5;
    localparam int TO    = 16;
    localparam int NEVER = 1000;

    logic            clk;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [31:0]     cmd_rs1;
    logic [31:0]     cmd_rs2;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_data;
    logic            rsp_err;
    logic [15:0]     op_a;
    logic [15:0]     op_b;
    logic [15:0]     op_c;
    logic [15:0]     op_d;
    logic [N-1:0]    op_stb;
    logic [N-1:0]    op_busy;
    logic [N*16-1:0] res_data;
    logic [N-1:0]    res_stb;
    logic [N-1:0]    res_ack;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] rop;
    int         w;

    synq_op_dispatcher #(
        .NUM_OPS       (N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_rs1  (cmd_rs1),
        .cmd_rs2  (cmd_rs2),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_c     (op_c),
        .op_d     (op_d),
        .op_stb   (op_stb),
        .op_busy  (op_busy),
        .res_data (res_data),
        .res_stb  (res_stb),
        .res_ack  (res_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // Lanes a..d as the units expect them for a given op.
    function automatic logic [63:0] ref_lanes(
        input logic [2:0]  op,
        input logic [31:0] r1,
        input logic [31:0] r2);
        logic [15:0] a;
        a = (op < 3'd2) ? r1[31:16] : r2[31:16];
        return {a, r1[15:0], r2[31:16], r2[15:0]};
    endfunction

    // One command: unit takes input on its bdel-th strobe cycle,
    // raises its result rdel cycles after that, holds until acked.
    task automatic do_cmd(
        input logic [2:0]   op,
        input logic [31:0]  r1,
        input logic [31:0]  r2,
        input logic [15:0]  res,
        input int           bdel,
        input int           rdel,
        input int           hold,
        input logic [N-1:0] noise,
        input bit           pre,
        input bit           keep);
        logic [N-1:0]    oh;
        logic [N*16-1:0] bus;
        logic [31:0]     exp_data;
        logic [31:0]     d0;
        logic            e0;
        bit              illegal;
        bit              exp_err;
        bit              stable;
        int              oi, stbn, acks, hs, rspn, n, exp_stbn;
        oi       = int'(op);
        illegal  = oi >= N;
        oh       = illegal ? '0 : (N'(1) << op);
        exp_err  = illegal || bdel >= TO || rdel > TO;
        exp_data = exp_err ? 32'h0 : {16'h0, res};
        for (int k = 0; k < N; k++) bus[k*16 +: 16] = 16'($urandom);
        if (!illegal) bus[oi*16 +: 16] = res;
        res_data = bus;
        noise    = noise & ~oh;
        if (!pre) begin
            n = 0;
            while (!cmd_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("cmd_ready", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b1;
            cmd_op    = op;
            cmd_rs1   = r1;
            cmd_rs2   = r2;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        res_stb = noise;
        hs = -1; stbn = 0; acks = 0; rspn = -1; n = 0;
        while (rspn < 0 && n < 64) begin
            if (op_stb !== '0) begin
                chk("op_stb", 64'(op_stb), 64'(oh));
                chk("lanes", {op_a, op_b, op_c, op_d},
                    ref_lanes(op, r1, r2));
            end
            if (res_ack !== '0) begin
                chk("res_ack", 64'(res_ack), 64'(oh));
                acks++;
                res_stb = noise;
            end
            if (rsp_valid === 1'b1) begin
                rspn = n;
            end else begin
                op_busy = '0;
                if ((op_stb & oh) != '0) begin
                    if (stbn == bdel) begin
                        op_busy = oh;
                        hs = n;
                    end
                    stbn++;
                end
                if (hs >= 0 && acks == 0 && n >= hs + rdel)
                    res_stb = noise | oh;
                @(negedge clk);
                n++;
            end
        end
        op_busy = '0;
        chk("rsp_seen", 64'(rspn >= 0), 64'd1);
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        chk("rsp_data", 64'(rsp_data), 64'(exp_data));
        chk("stb_at_rsp", 64'(op_stb), 64'd0);
        chk("ack_count", 64'(acks), exp_err ? 64'd0 : 64'd1);
        if (illegal) exp_stbn = 0;
        else if (bdel >= TO) exp_stbn = TO;
        else exp_stbn = bdel + 1;
        chk("stb_cycles", 64'(stbn), 64'(exp_stbn));
        if (!illegal && bdel >= TO)
            chk("to_issue_cyc", 64'(rspn), 64'(TO));
        else if (!illegal && rdel > TO)
            chk("to_wait_cyc", 64'(rspn), 64'(bdel + 1 + TO));
        d0 = rsp_data;
        e0 = rsp_err;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!(rsp_valid === 1'b1 && rsp_data === d0 &&
                  rsp_err === e0 && cmd_ready === 1'b0 &&
                  res_ack === '0 && op_stb === '0))
                stable = 1'b0;
        end
        chk("rsp_hold", 64'(stable), 64'd1);
        if (!keep) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            chk("rsp_drop", 64'(rsp_valid), 64'd0);
        end
        res_stb = '0;
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_rs1   = '0;
        cmd_rs2   = '0;
        rsp_ready = 1'b0;
        op_busy   = '0;
        res_data  = '0;
        res_stb   = '0;
        #12;
        chk("rst_ctl", 64'({cmd_ready, rsp_valid, rsp_err,
                            op_stb, res_ack}), 64'd0);
        chk("rst_lanes", {op_a, op_b, op_c, op_d}, 64'd0);
        chk("rst_data", 64'(rsp_data), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 64'(cmd_ready), 64'd1);

        do_cmd(3'd0, 32'h3C00_4000, 32'h4200_4400, 16'h4A00,
               1, 2, 0, '0, 0, 0);
        do_cmd(3'd6, $urandom, $urandom, 16'h1234,
               0, 0, 2, '0, 0, 0);
        do_cmd(3'd2, $urandom, $urandom, 16'h1111,
               NEVER, 0, 1, '0, 0, 0);
        do_cmd(3'd1, $urandom, $urandom, 16'h2222,
               0, NEVER, 1, '0, 0, 0);
        do_cmd(3'd3, $urandom, $urandom, 16'h3C3C,
               1, 0, 1, 5'b00010, 0, 0);
        do_cmd(3'd4, $urandom, $urandom, 16'h7E00,
               0, 3, 10, '0, 0, 1);

        // Response taken with the next command already waiting.
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_rs1   = 32'h1111_2222;
        cmd_rs2   = 32'h3333_4444;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("b2b_rsp_drop", 64'(rsp_valid), 64'd0);
        chk("b2b_ready", 64'(cmd_ready), 64'd1);
        chk("b2b_bubble", 64'(op_stb), 64'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_accept", 64'(op_stb), 64'b00100);
        chk("b2b_busy", 64'(cmd_ready), 64'd0);
        do_cmd(3'd2, 32'h1111_2222, 32'h3333_4444, 16'h5A5A,
               0, 1, 0, '0, 1, 0);

        // Async reset while strobing a unit.
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_issue", 64'(op_stb), 64'b00100);
        #2 rst = 1'b0;
        #1 chk("rst_issue", 64'({op_stb, res_ack, rsp_valid}), 64'd0);
        @(negedge clk);
        #2 rst = 1'b1;

        // Async reset in the acknowledge cycle.
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        op_busy   = 5'b10000;
        @(negedge clk);
        op_busy   = '0;
        chk("rst_wait_stb", 64'(op_stb), 64'd0);
        res_data[79:64] = 16'hBEEF;
        res_stb   = 5'b10000;
        @(negedge clk);
        chk("rst_pre_ack", 64'({res_ack, rsp_valid}), 64'b100001);
        #2 rst = 1'b0;
        #1 chk("rst_ack", 64'({op_stb, res_ack, rsp_valid}), 64'd0);
        res_stb = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        do_cmd(3'd4, $urandom, $urandom, 16'hC0DE,
               0, 1, 0, '0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 6) == 0)
                rop = 3'(5 + $urandom_range(0, 2));
            else
                rop = 3'($urandom_range(0, 4));
            do_cmd(rop, $urandom, $urandom, 16'($urandom),
                   $urandom_range(0, 4), $urandom_range(0, 5),
                   $urandom_range(0, 3), N'($urandom), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
